pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch/next-PC controller for the CPU core. Holds the architectural PC and runs the instruction-memory fetch handshake. Presents each fetched instruction to the execute datapath, then selects the next PC from sequential, branch/JAL or JALR redirects. JALR targets have bit 0 cleared, and misaligned targets divert to a fixed trap vector.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  32  fetch address, equals PC
- IMEM_ACK  in  1  fetch complete; IMEM_RDATA valid this cycle
- IMEM_RDATA  in  32  fetched instruction word
- INSTR  out  32  latched instruction for the datapath
- INSTR_VALID  out  1  INSTR holds an instruction awaiting execution
- CORE_DONE  in  1  datapath finished current instruction; redirect inputs valid this cycle
- BR_TAKEN  in  1  conditional branch taken
- JAL  in  1  JAL executed
- JALR  in  1  JALR executed
- BR_TARGET  in  32  PC+imm from datapath adder (branch/JAL)
- JALR_BASE  in  32  rs1+imm (JALR, bit 0 not yet cleared)
- PC  out  32  current PC
- TRAP  out  1  one-cycle pulse on misaligned target
- MEPC  out  32  PC of the instruction that caused the last trap

## Operation
- States: IDLE, FETCH, EXEC, TRAP.
- Reset values: state=IDLE, PC=RESET_PC, IMEM_REQ=0, INSTR=0, INSTR_VALID=0, TRAP=0, MEPC=0.
- IDLE: always goes to FETCH next cycle.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC, both stable until IMEM_ACK is sampled high.
  - On ACK: INSTR<=IMEM_RDATA, INSTR_VALID<=1, go to EXEC, IMEM_REQ drops.
- EXEC: waits for CORE_DONE. On CORE_DONE, candidate next PC is chosen by priority:
  - JALR: {JALR_BASE[31:1],1'b0}
  - else JAL or BR_TAKEN: BR_TARGET
  - else PC+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 32'h0000_0000)
- Misalignment check: candidate[1:0] != 0 (after the JALR bit-0 clear).
  - Misaligned: MEPC<=PC, go to TRAP, PC unchanged.
  - Aligned: PC<=candidate, go to FETCH.
  - In both cases INSTR_VALID<=0.
- TRAP: TRAP=1 for exactly this cycle, PC<=TRAP_VEC, go to FETCH.
- Simultaneous redirect flags: JALR beats JAL beats BR_TAKEN.
- Inputs sampled only where they apply:
  - IMEM_ACK ignored outside FETCH.
  - CORE_DONE and the redirect flags ignored outside EXEC.
- Reset mid-operation (any state, including mid-fetch): reset values apply at the next edge, so IMEM_REQ drops. A late IMEM_ACK arriving in IDLE is ignored.

## Timing
- IMEM_REQ rises on the first edge after reset release (IDLE -> FETCH).
- Zero-wait memory (ACK in the first FETCH cycle): INSTR_VALID is high the following cycle.
- Minimum throughput: 2 cycles per instruction (1 FETCH + 1 EXEC). Each memory wait cycle adds 1, each datapath wait cycle adds 1.
- PC updates on the CORE_DONE edge, so IMEM_ADDR shows the new PC in the very next FETCH cycle.
- A trapped instruction costs 1 extra cycle (the TRAP state) before the fetch from TRAP_VEC.
- All outputs are registered; none depends combinationally on an input.

## Structure
- Shared package holds:
  - state encodings (2-bit)
  - INSTR_BYTES=4
  - default RESET_PC and TRAP_VEC constants
- One combinational sub-module, next_pc_sel:
  - inputs: PC, flags, BR_TARGET, JALR_BASE
  - outputs: candidate next PC (JALR bit-0 clear included) and a misaligned flag
- The FSM and registers live in pc_sequencer.

## Test plan
- Reset release, memory ACKs immediately, CORE_DONE with no redirect -> IMEM_ADDR sequence 0x0, 0x4, 0x8; INSTR_VALID high every second cycle.
- JALR with JALR_BASE=0x0000_1003 -> next IMEM_ADDR=0x0000_1002 is misaligned (bit 1 set) -> TRAP pulse, MEPC=old PC, next IMEM_ADDR=0x100. With JALR_BASE=0x0000_1005 -> next IMEM_ADDR=0x0000_1004, no trap.
- JALR, JAL and BR_TAKEN all high, BR_TARGET=0x40, JALR_BASE=0x81 -> next PC=0x80.
- PC=0xFFFF_FFFC, no redirect -> next IMEM_ADDR=0x0000_0000.
- Memory ACK delayed 3 cycles -> IMEM_REQ and IMEM_ADDR stable for all 3 cycles; INSTR captures IMEM_RDATA only on the ACK cycle.
- RST asserted during FETCH with a pending ACK one cycle later -> IMEM_REQ=0 next cycle, PC=RESET_PC, ACK ignored, INSTR_VALID stays 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the fetch/next-PC controller:
//   state_t           - 2-bit FSM state encoding (IDLE, FETCH, EXEC, TRAP)
//   INSTR_BYTES       - size of one instruction word in bytes
//   DEFAULT_RESET_PC  - default PC loaded on reset
//   DEFAULT_TRAP_VEC  - default PC loaded on a misaligned-target trap
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// pc_sequencer_next_pc_sel
// Purely combinational next-PC selection.
// Ports:
//   pc         in  32  current PC
//   br_taken   in  1   conditional branch taken
//   jal        in  1   JAL executed
//   jalr       in  1   JALR executed
//   br_target  in  32  PC+imm (branch/JAL target)
//   jalr_base  in  32  rs1+imm (JALR target before bit-0 clear)
//   candidate  out 32  selected next PC
//   misaligned out 1   candidate is not word aligned
module pc_sequencer_next_pc_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_base,
  output logic [31:0] candidate,
  output logic        misaligned
);

  // Priority: JALR over JAL over taken branch over sequential.
  // The sequential add wraps naturally at 32 bits.
  always_comb begin
    candidate = pc + 32'(INSTR_BYTES);
    if (jalr) begin
      // Masking rather than slicing keeps every bit of jalr_base in use.
      candidate = jalr_base & ~32'h0000_0001;
    end else if (jal || br_taken) begin
      candidate = br_target;
    end
    // Checked after the JALR bit-0 clear, so only bit 1 can trip a JALR.
    misaligned = (candidate[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-cycle fetch/next-PC controller. Holds the architectural PC, runs the
// instruction-memory request/ack handshake, presents the fetched word to the
// datapath and advances the PC on CORE_DONE, diverting misaligned targets to
// TRAP_VEC.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   imem_req/addr      fetch request and address (address equals pc)
//   imem_ack/rdata     fetch complete and instruction word
//   instr/instr_valid  latched instruction and its pending-execution flag
//   core_done          datapath finished; redirect inputs valid this cycle
//   br_taken/jal/jalr  redirect flags
//   br_target          branch/JAL target
//   jalr_base          JALR target before bit-0 clear
//   pc                 current PC
//   trap               one-cycle pulse while in the TRAP state
//   mepc               PC of the instruction that last trapped
// All outputs come straight from registers.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        core_done,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_base,
  output logic [31:0] pc,
  output logic        trap,
  output logic [31:0] mepc
);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        imem_req_reg;
  logic [31:0] instr_reg;
  logic        instr_valid_reg;
  logic        trap_reg;
  logic [31:0] mepc_reg;

  logic [31:0] candidate_next;
  logic        misaligned_next;

  pc_sequencer_next_pc_sel u_next_pc_sel (
    .pc         (pc_reg),
    .br_taken   (br_taken),
    .jal        (jal),
    .jalr       (jalr),
    .br_target  (br_target),
    .jalr_base  (jalr_base),
    .candidate  (candidate_next),
    .misaligned (misaligned_next)
  );

  // imem_req and trap are registered alongside the state transition so that
  // they reflect the state being entered, not the one being left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_PC;
      imem_req_reg    <= 1'b0;
      instr_reg       <= 32'h0000_0000;
      instr_valid_reg <= 1'b0;
      trap_reg        <= 1'b0;
      mepc_reg        <= 32'h0000_0000;
    end else begin
      trap_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          state_reg    <= ST_FETCH;
          imem_req_reg <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (core_done) begin
            instr_valid_reg <= 1'b0;
            if (misaligned_next) begin
              // PC is left pointing at the faulting instruction.
              mepc_reg  <= pc_reg;
              trap_reg  <= 1'b1;
              state_reg <= ST_TRAP;
            end else begin
              pc_reg       <= candidate_next;
              imem_req_reg <= 1'b1;
              state_reg    <= ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          pc_reg       <= TRAP_VEC;
          imem_req_reg <= 1'b1;
          state_reg    <= ST_FETCH;
        end
        default: begin
          state_reg    <= ST_IDLE;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign trap        = trap_reg;
  assign mepc        = mepc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed stimulus with a scoreboard: the stimulus side pushes expected fetch
// addresses, instruction words and trap MEPC values into queues; a monitor on
// the falling edge pops and compares whenever the DUT completes a fetch,
// raises INSTR_VALID, or pulses TRAP.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        core_done;
  logic        br_taken;
  logic        jal;
  logic        jalr;
  logic [31:0] br_target;
  logic [31:0] jalr_base;
  logic [31:0] pc;
  logic        trap;
  logic [31:0] mepc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_mepc_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .core_done   (core_done),
    .br_taken    (br_taken),
    .jal         (jal),
    .jalr        (jalr),
    .br_target   (br_target),
    .jalr_base   (jalr_base),
    .pc          (pc),
    .trap        (trap),
    .mepc        (mepc)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Monitor: compares DUT-presented events against the scoreboard queues.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_ack) begin
        if (exp_fetch_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL fetch_unexpected: got addr 0x%08h, expected no fetch", imem_addr);
        end else begin
          check32("fetch_addr", imem_addr, exp_fetch_q.pop_front());
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_instr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL instr_unexpected: got 0x%08h, expected no instruction", instr);
        end else begin
          check32("instr_word", instr, exp_instr_q.pop_front());
        end
      end
      prev_valid = instr_valid;
      if (trap) begin
        if (exp_mepc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL trap_unexpected: got mepc 0x%08h, expected no trap", mepc);
        end else begin
          check32("trap_mepc", mepc, exp_mepc_q.pop_front());
        end
      end
    end
  end

  // One fetch + execute. Inputs change #1 after the rising edge.
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] word,
                           input int mem_wait, input int done_wait,
                           input logic f_jalr, input logic f_jal, input logic f_br,
                           input logic [31:0] tgt, input logic [31:0] base);
    int n;
    n = 0;
    exp_fetch_q.push_back(addr);
    exp_instr_q.push_back(word);
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      n_checks++; n_fail++;
      $display("FAIL fetch_timeout: got imem_req 0 after %0d cycles, expected 1", n);
      return;
    end
    check32("fetch_addr_start", imem_addr, addr);
    // Memory wait cycles: redirect inputs are driven but must be ignored.
    for (int w = 0; w < mem_wait; w++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      core_done  = 1'b1;
      jalr       = 1'b1;
      jalr_base  = 32'h0000_5555;
      @(posedge clk); #1;
      check1("wait_req_stable", imem_req, 1'b1);
      check32("wait_addr_stable", imem_addr, addr);
      check1("wait_valid_low", instr_valid, 1'b0);
    end
    core_done  = 1'b0;
    jalr       = 1'b0;
    jalr_base  = 32'h0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check1("valid_after_ack", instr_valid, 1'b1);
    check1("req_drop_after_ack", imem_req, 1'b0);
    // Datapath wait cycles: a stray ACK must not overwrite INSTR.
    for (int d = 0; d < done_wait; d++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~word;
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      check32("instr_hold_exec", instr, word);
    end
    core_done = 1'b1;
    jalr      = f_jalr;
    jal       = f_jal;
    br_taken  = f_br;
    br_target = tgt;
    jalr_base = base;
    @(posedge clk); #1;
    core_done = 1'b0;
    jalr      = 1'b0;
    jal       = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    jalr_base = 32'h0;
    check1("valid_clear_done", instr_valid, 1'b0);
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; core_done = 1'b0;
    br_taken = 1'b0; jal = 1'b0; jalr = 1'b0; br_target = 32'h0; jalr_base = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_req", imem_req, 1'b0);
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, 32'h0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_trap", trap, 1'b0);
    check32("rst_mepc", mepc, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check1("req_after_release", imem_req, 1'b1);

    // Sequential fetches 0x0, 0x4, 0x8.
    run_instr(32'h0000_0000, 32'h1111_0001, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    run_instr(32'h0000_0004, 32'h1111_0002, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    // JALR to 0x1003 -> 0x1002, misaligned -> trap with MEPC=0x8, then 0x100.
    exp_mepc_q.push_back(32'h0000_0008);
    run_instr(32'h0000_0008, 32'h1111_0003, 0, 0, 1, 0, 0, 32'h0, 32'h0000_1003);
    check1("trap_pulse", trap, 1'b1);
    check32("trap_pc_hold", pc, 32'h0000_0008);
    // JALR to 0x1005 -> 0x1004, aligned.
    run_instr(32'h0000_0100, 32'h1111_0004, 0, 0, 1, 0, 0, 32'h0, 32'h0000_1005);
    // All redirect flags: JALR wins -> 0x80.
    run_instr(32'h0000_1004, 32'h1111_0005, 0, 0, 1, 1, 1, 32'h0000_0040, 32'h0000_0081);
    // JAL with datapath wait cycles -> 0x200.
    run_instr(32'h0000_0080, 32'h1111_0006, 0, 2, 0, 1, 0, 32'h0000_0200, 32'h0);
    // Taken branch to the top word.
    run_instr(32'h0000_0200, 32'h1111_0007, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    // Wrap 0xFFFF_FFFC -> 0x0 with a 3-cycle memory wait.
    run_instr(32'hFFFF_FFFC, 32'h1111_0008, 3, 0, 0, 0, 0, 32'h0, 32'h0);
    run_instr(32'h0000_0000, 32'h1111_0009, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    // Misaligned branch target 0x302 -> trap with MEPC=0x4.
    exp_mepc_q.push_back(32'h0000_0004);
    run_instr(32'h0000_0004, 32'h1111_000A, 0, 0, 0, 0, 1, 32'h0000_0302, 32'h0);
    run_instr(32'h0000_0100, 32'h1111_000B, 1, 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset during the fetch of 0x104, ACK arriving one cycle later in IDLE.
    check1("pre_rst_fetching", imem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    check1("midrst_req", imem_req, 1'b0);
    check32("midrst_pc", pc, 32'h0);
    check32("midrst_mepc", mepc, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_1234;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    check1("late_ack_valid", instr_valid, 1'b0);
    check32("late_ack_instr", instr, 32'h0);
    check1("late_ack_req", imem_req, 1'b1);
    run_instr(32'h0000_0000, 32'h1111_000C, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check32("final_pc", pc, 32'h0000_0004);

    repeat (2) @(posedge clk);
    #1;
    check32("fetch_q_drained", exp_fetch_q.size(), 32'd0);
    check32("instr_q_drained", exp_instr_q.size(), 32'd0);
    check32("mepc_q_drained", exp_mepc_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
